i2c_target_regs: RTL and testbench

- I2C target (responder) at the far end of the robot's I2C bus; mirrors the on-chip bus master.
- Used as a sensor emulator in system benches and as a debug register port for the PID/motor setpoints.
- Decodes START/STOP, matches a 7-bit address, then accepts register-pointer and data writes, or returns read data.
- Accesses a host-side register bank through a simple strobe/address/data interface.

---
 rtl/i2c_target_regs.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target exposing a host register bank: 7-bit address match, pointer write, auto-incrementing data writes/reads.
// Bus events lag the pins by SYNC_STAGES+1 clk_in (+FILT_CYCLES when I2C_GLITCH_FILT_EN is defined); never stretches SCL.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h29,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_CYCLES = 4
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe_out,
  output logic [7:0] reg_addr_out,
  input  logic [7:0] reg_rdata_in,
  output logic       reg_wr_out,
  output logic [7:0] reg_wdata_out,
  output logic       busy_out
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, MACK, IGNORE
  } state_t;

  if (SYNC_STAGES < 2 || FILT_CYCLES < 2) begin : g_bad_cfg
    $error("i2c_target_regs: SYNC_STAGES and FILT_CYCLES must both be at least 2");
  end

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl, sda, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILT_EN
  localparam int CW = $clog2(FILT_CYCLES + 1);
  logic [1:0]    raw, filt;
  logic [CW-1:0] filt_cnt [2];

  assign raw = {scl_sync[SYNC_STAGES-1], sda_sync[SYNC_STAGES-1]};

  // A line only changes once the new level has held for FILT_CYCLES samples.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_in) begin
        filt[i]     <= 1'b1;
        filt_cnt[i] <= '0;
      end else if (raw[i] == filt[i]) begin
        filt_cnt[i] <= '0;
      end else if (filt_cnt[i] == CW'(FILT_CYCLES - 1)) begin
        filt[i]     <= raw[i];
        filt_cnt[i] <= '0;
      end else begin
        filt_cnt[i] <= filt_cnt[i] + 1'b1;
      end
    end
  end

  assign scl = filt[1];
  assign sda = filt[0];
`else
  assign scl = scl_sync[SYNC_STAGES-1];
  assign sda = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] shift, shift_nxt, byte_in;
  logic       rw, rw_nxt;
  logic       sda_oe_nxt, wr_nxt, busy_nxt;
  logic [7:0] addr_nxt, wdata_nxt;

  assign byte_in = {shift[6:0], sda};

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state         <= IDLE;
      cnt           <= '0;
      shift         <= '0;
      rw            <= 1'b0;
      sda_oe_out    <= 1'b0;
      reg_addr_out  <= '0;
      reg_wr_out    <= 1'b0;
      reg_wdata_out <= '0;
      busy_out      <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      shift         <= shift_nxt;
      rw            <= rw_nxt;
      sda_oe_out    <= sda_oe_nxt;
      reg_addr_out  <= addr_nxt;
      reg_wr_out    <= wr_nxt;
      reg_wdata_out <= wdata_nxt;
      busy_out      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shift_nxt  = shift;
    rw_nxt     = rw;
    sda_oe_nxt = sda_oe_out;
    addr_nxt   = reg_wr_out ? reg_addr_out + 8'd1 : reg_addr_out;
    wr_nxt     = 1'b0;
    wdata_nxt  = reg_wdata_out;
    busy_nxt   = busy_out;
    if (start_det) begin
      state_nxt  = ADDR;
      cnt_nxt    = '0;
      sda_oe_nxt = 1'b0;
    end else if (stop_det) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WRITE: begin
          if (scl_rise) begin
            shift_nxt = byte_in;
            cnt_nxt   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_nxt = '0;
              if (state == ADDR) begin
                if (byte_in[7:1] == TARGET_ADDR && TARGET_ADDR != 7'd0) begin
                  state_nxt = ADDR_ACK;
                  busy_nxt  = 1'b1;
                  rw_nxt    = byte_in[0];
                end else begin
                  state_nxt = IGNORE;
                  busy_nxt  = 1'b0;
                end
              end else if (state == PTR) begin
                addr_nxt  = byte_in;
                state_nxt = PTR_ACK;
              end else begin
                wr_nxt    = 1'b1;
                wdata_nxt = byte_in;
                state_nxt = WRITE_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WRITE_ACK: begin
          // First fall starts driving the ACK, the second one ends it.
          if (scl_fall) begin
            if (!sda_oe_out) begin
              sda_oe_nxt = 1'b1;
            end else begin
              cnt_nxt = '0;
              if (state == ADDR_ACK && rw) begin
                shift_nxt  = reg_rdata_in;
                sda_oe_nxt = ~reg_rdata_in[7];
                state_nxt  = READ;
              end else begin
                sda_oe_nxt = 1'b0;
                state_nxt  = (state == ADDR_ACK) ? PTR : WRITE;
              end
            end
          end
        end
        READ: begin
          if (scl_rise) cnt_nxt = cnt + 4'd1;
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_oe_nxt = 1'b0;
              cnt_nxt    = '0;
              state_nxt  = MACK;
            end else begin
              shift_nxt  = {shift[6:0], 1'b0};
              sda_oe_nxt = ~shift[6];
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (!sda) begin
              addr_nxt = reg_addr_out + 8'd1;
              cnt_nxt  = 4'd1;
            end else begin
              state_nxt = IGNORE;
              busy_nxt  = 1'b0;
            end
          end else if (scl_fall && cnt == 4'd1) begin
            shift_nxt  = reg_rdata_in;
            sda_oe_nxt = ~reg_rdata_in[7];
            cnt_nxt    = '0;
            state_nxt  = READ;
          end
        end
        IDLE, IGNORE: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, host register bank, queue-based scoreboard with a byte-level model.
module tb_i2c_target_regs;
  localparam int Q = 6;

  logic       clk_in = 1'b0;
  logic       reset_in, scl_m, sda_m, sda_line;
  logic       sda_oe_out, reg_wr_out, busy_out;
  logic [7:0] reg_addr_out, reg_rdata_in, reg_wdata_out;

  always #5 clk_in = ~clk_in;

  i2c_target_regs dut (
    .clk_in(clk_in), .reset_in(reset_in), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe_out(sda_oe_out), .reg_addr_out(reg_addr_out), .reg_rdata_in(reg_rdata_in),
    .reg_wr_out(reg_wr_out), .reg_wdata_out(reg_wdata_out), .busy_out(busy_out)
  );

  logic [7:0]  host_mem [256];
  logic [7:0]  model_mem [256];
  logic [7:0]  model_ptr;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_bus [$];
  logic [7:0]  act_bus [$];
  int n_cmp = 0, n_bad = 0;
  bit oe_watch = 0, oe_seen = 0;

  assign sda_line     = sda_m & ~sda_oe_out;
  assign reg_rdata_in = host_mem[reg_addr_out];

  always @(posedge clk_in) if (reset_in && reg_wr_out) host_mem[reg_addr_out] <= reg_wdata_out;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [15:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  // Scoreboard monitors: write strobes and bytes/ACK bits seen on the bus.
  always @(negedge clk_in) begin
    if (oe_watch && sda_oe_out) oe_seen = 1;
    if (reset_in && reg_wr_out) begin
      if (exp_wr.size() == 0) unexpected("strobe", {reg_addr_out, reg_wdata_out});
      else check("strobe", {reg_addr_out, reg_wdata_out}, exp_wr.pop_front());
    end
    if (act_bus.size() > 0) begin
      if (exp_bus.size() == 0) unexpected("bus", {8'h0, act_bus.pop_front()});
      else check("bus", {8'h0, act_bus.pop_front()}, {8'h0, exp_bus.pop_front()});
    end
  end

  task automatic wq();
    repeat (Q) @(negedge clk_in);
  endtask

  task automatic i2c_start();
    sda_m = 1; wq(); scl_m = 1; wq(); sda_m = 0; wq(); scl_m = 0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 0; wq(); scl_m = 1; wq(); sda_m = 1; wq(); wq();
  endtask

  task automatic clk_bit(input logic b, input bit glitch, output logic s);
    sda_m = b; wq(); scl_m = 1;
    if (glitch) begin
      repeat (2) @(negedge clk_in); sda_m = 0;
      repeat (2) @(negedge clk_in); sda_m = 1;
      repeat (Q - 4) @(negedge clk_in);
    end else begin
      wq();
    end
    s = sda_line; wq(); scl_m = 0; wq();
  endtask

  task automatic send_byte(input logic [7:0] d, input bit glitch);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], glitch && i == 7, s);
    clk_bit(1'b1, 1'b0, s);
    act_bus.push_back({7'h0, s});
  endtask

  task automatic recv_byte(input logic nack);
    logic s;
    logic [7:0] r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s);
      r[i] = s;
    end
    act_bus.push_back(r);
    clk_bit(nack, 1'b0, s);
  endtask

  // Model: first byte after an accepted write address is the pointer, later bytes are stored and bump it.
  task automatic wr_txn(input logic [7:0] ab, input logic [31:0] d, input int n, input int gbyte);
    bit hit, acc;
    logic [7:0] b;
    hit = (ab[7:1] == 7'h29) && !ab[0];
    acc = hit;
    i2c_start();
    exp_bus.push_back(acc ? 8'h0 : 8'h1);
    send_byte(ab, 1'b0);
    check("busy_addr", {15'h0, busy_out}, {15'h0, hit});
    for (int i = 0; i < n; i++) begin
      b = d[8*(3-i) +: 8];
`ifndef I2C_GLITCH_FILT_EN
      if (i == gbyte) acc = 0;
`endif
      if (acc) begin
        if (i == 0) model_ptr = b;
        else begin
          exp_wr.push_back({model_ptr, b});
          model_mem[model_ptr] = b;
          model_ptr = model_ptr + 8'd1;
        end
      end
      exp_bus.push_back(acc ? 8'h0 : 8'h1);
      send_byte(b, i == gbyte);
    end
    if (gbyte >= 0) check("busy_glitch", {15'h0, busy_out}, {15'h0, acc});
    i2c_stop();
    check("busy_stop", {15'h0, busy_out}, 16'h0);
    if (hit) check("ptr_end", {8'h0, reg_addr_out}, {8'h0, model_ptr});
  endtask

  task automatic rd_txn(input logic [7:0] ptr, input int n);
    i2c_start();
    exp_bus.push_back(8'h0); send_byte(8'h52, 1'b0);
    exp_bus.push_back(8'h0); send_byte(ptr, 1'b0);
    model_ptr = ptr;
    i2c_start();
    exp_bus.push_back(8'h0); send_byte(8'h53, 1'b0);
    check("busy_read", {15'h0, busy_out}, 16'h1);
    for (int i = 0; i < n; i++) begin
      exp_bus.push_back(model_mem[model_ptr]);
      recv_byte(i == n - 1);
      if (i < n - 1) model_ptr = model_ptr + 8'd1;
    end
    check("busy_nack", {15'h0, busy_out}, 16'h0);
    i2c_stop();
    check("ptr_read", {8'h0, reg_addr_out}, {8'h0, model_ptr});
  endtask

  initial begin
    logic s;
    reset_in = 0; scl_m = 1; sda_m = 1;
    for (int i = 0; i < 256; i++) begin
      host_mem[i] = 8'($urandom);
      model_mem[i] = host_mem[i];
    end
    model_ptr = 8'h0;
    repeat (4) @(negedge clk_in);
    check("rst_oe", {15'h0, sda_oe_out}, 16'h0);
    check("rst_addr", {8'h0, reg_addr_out}, 16'h0);
    check("rst_wr", {15'h0, reg_wr_out}, 16'h0);
    check("rst_wdata", {8'h0, reg_wdata_out}, 16'h0);
    check("rst_busy", {15'h0, busy_out}, 16'h0);
    reset_in = 1;
    repeat (4) @(negedge clk_in);

    wr_txn(8'h52, 32'h10A53C00, 3, -1);

    host_mem[8'h20] = 8'h7E; model_mem[8'h20] = 8'h7E;
    host_mem[8'h21] = 8'h81; model_mem[8'h21] = 8'h81;
    rd_txn(8'h20, 2);

    oe_watch = 1; oe_seen = 0;
    wr_txn(8'h54, 32'hFF000000, 1, -1);
    oe_watch = 0;
    check("wrong_addr_oe", {15'h0, oe_seen}, 16'h0);

    wr_txn(8'h52, 32'hFF010200, 3, -1);
    wr_txn(8'h52, 32'h40FF0000, 2, 1);

    // Abort a read in mid-byte with reset; the target must let go of SDA at once.
    host_mem[8'h30] = 8'h00; model_mem[8'h30] = 8'h00;
    i2c_start();
    exp_bus.push_back(8'h0); send_byte(8'h52, 1'b0);
    exp_bus.push_back(8'h0); send_byte(8'h30, 1'b0);
    i2c_start();
    exp_bus.push_back(8'h0); send_byte(8'h53, 1'b0);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, 1'b0, s);
    sda_m = 1; wq(); scl_m = 1; wq();
    check("abort_drive", {15'h0, sda_oe_out}, 16'h1);
    reset_in = 0;
    @(negedge clk_in);
    check("abort_oe", {15'h0, sda_oe_out}, 16'h0);
    check("abort_busy", {15'h0, busy_out}, 16'h0);
    check("abort_addr", {8'h0, reg_addr_out}, 16'h0);
    reset_in = 1;
    model_ptr = 8'h0;
    scl_m = 0; wq(); wq();
    i2c_stop();
    wr_txn(8'h52, 32'h55123400, 3, -1);

    for (int t = 0; t < 10; t++) begin
      int kind, n;
      logic [6:0] a7;
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 3);
      if (kind == 0) rd_txn(8'($urandom), n);
      else if (kind == 1) wr_txn(8'h52, $urandom, n + 1, -1);
      else begin
        a7 = 7'($urandom_range(0, 127));
        if (a7 == 7'h29) a7 = 7'h2A;
        wr_txn({a7, 1'b0}, $urandom, n, -1);
      end
    end

    repeat (20) @(negedge clk_in);
    check("exp_wr_left", 16'(exp_wr.size()), 16'h0);
    check("exp_bus_left", 16'(exp_bus.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
